// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: skews A lanes per row and B lanes per column,
// sequences PE clear/enable and flags done. Optional k-slot counter: SYSTOLIC_FEEDER_KCOUNT_EN.
module systolic_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DATA_W-1:0] a_col,
  input  logic [N*DATA_W-1:0] b_row,
  output logic [N*DATA_W-1:0] a_feed,
  output logic [N*DATA_W-1:0] b_feed,
  output logic                pe_clr,
  output logic                pe_en,
  output logic                busy,
  output logic                done,
`ifdef SYSTOLIC_FEEDER_KCOUNT_EN
  output logic [15:0]         k_count,
`endif
  output logic [2:0]          state_dbg
);

  // Handshake: a slot is accepted on a rising edge where in_valid && in_ready; the source
  // holds a_col/b_row/in_last stable while in_valid is high and in_ready is low.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int             CW         = $clog2(2 * N);
  localparam logic [CW-1:0]  FLUSH_LOAD = CW'(2 * N - 1);

  state_t              state, next_state;
  logic [CW-1:0]       flush_cnt;
  logic                accept;
  logic                pe_clr_d, pe_en_d, busy_d, done_d;
  logic [N*DATA_W-1:0] push_a, push_b;

  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR:  next_state = S_STREAM;
      S_STREAM: if (accept && in_last) next_state = S_FLUSH;
      S_FLUSH:  if (flush_cnt == CW'(1)) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Control outputs are decoded from next_state and registered so they align with state.
  always_comb begin
    in_ready = (state == S_STREAM);
    pe_clr_d = (next_state == S_CLEAR);
    pe_en_d  = (next_state == S_STREAM) || (next_state == S_FLUSH);
    busy_d   = (next_state != S_IDLE);
    done_d   = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_clr <= 1'b0;
      pe_en  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pe_clr <= pe_clr_d;
      pe_en  <= pe_en_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Loaded on the final acceptance; the last product reaches PE[N-1][N-1] 2N-1 cycles later.
  always_ff @(posedge clk) begin
    if (rst)                                            flush_cnt <= '0;
    else if (state == S_STREAM && accept && in_last)    flush_cnt <= FLUSH_LOAD;
    else if (state == S_FLUSH)                          flush_cnt <= flush_cnt - CW'(1);
  end

  // Outside STREAM, or with no valid slot, a zero bubble enters the skew line.
  assign push_a = (state == S_STREAM && in_valid) ? a_col : '0;
  assign push_b = (state == S_STREAM && in_valid) ? b_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_sr [i+1];
    logic [DATA_W-1:0] b_sr [i+1];

    always_ff @(posedge clk) begin
      if (rst || state == S_CLEAR) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= push_a[i*DATA_W +: DATA_W];
        b_sr[0] <= push_b[i*DATA_W +: DATA_W];
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign a_feed[i*DATA_W +: DATA_W] = a_sr[i];
    assign b_feed[i*DATA_W +: DATA_W] = b_sr[i];
  end

`ifdef SYSTOLIC_FEEDER_KCOUNT_EN
  // Cleared as the op starts so the previous total stays visible through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst)                               k_count <= '0;
    else if (state == S_IDLE && start)     k_count <= '0;
    else if (accept && k_count != 16'hFFFF) k_count <= k_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: reset, skew timing, identity/bubble ops against a
// behavioural PE array, ignored start, mid-op reset and (optionally) k_count.
module tb_systolic_feeder;
  localparam int N  = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, in_last;
  logic            in_ready, pe_clr, pe_en, busy, done;
  logic [N*DW-1:0] a_col, b_row, a_feed, b_feed;
  logic [2:0]      state_dbg;
`ifdef SYSTOLIC_FEEDER_KCOUNT_EN
  logic [15:0]     k_count;
`endif

  int tests = 0;
  int fails = 0;

  systolic_feeder #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_col(a_col), .b_row(b_row), .a_feed(a_feed), .b_feed(b_feed),
    .pe_clr(pe_clr), .pe_en(pe_en), .busy(busy), .done(done),
`ifdef SYSTOLIC_FEEDER_KCOUNT_EN
    .k_count(k_count),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  // Behavioural PE array fed by the DUT
  logic [DW-1:0] pa  [N][N];
  logic [DW-1:0] pb  [N][N];
  logic [31:0]   acc [N][N];

  function automatic logic [DW-1:0] pe_a(int i, int j);
    if (j == 0) return a_feed[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] pe_b(int i, int j);
    if (i == 0) return b_feed[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || pe_clr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j] <= pe_a(i, j);
          pb[i][j] <= pe_b(i, j);
          if (pe_en) acc[i][j] <= acc[i][j] + 32'(pe_a(i, j)) * 32'(pe_b(i, j));
        end
      end
    end
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_op();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic drive_slot(input int k, input logic valid, input logic last);
    in_valid = valid;
    in_last  = last;
    for (int l = 0; l < N; l++) begin
      a_col[l*DW +: DW] = (l == k) ? DW'(1) : DW'(0);
      b_row[l*DW +: DW] = DW'(k * 8 + l);
    end
  endtask

  // Called one cycle after the in_last acceptance (t0 = cycles since acceptance).
  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int t = t0; t <= 40; t++) begin
      if (done) begin
        lat = t;
        break;
      end
      step();
    end
  endtask

  task automatic check_identity_acc(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s[%0d][%0d]", tag, i, j), 64'(acc[i][j]), 64'(i * 8 + j));
  endtask

  int lat;
  int seen;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_col = '0; b_row = '0;
    step();
    step();
    check("rst_a_feed", 64'(a_feed), 64'd0);
    check("rst_b_feed", 64'(b_feed), 64'd0);
    check("rst_pe_clr", 64'(pe_clr), 64'd0);
    check("rst_pe_en", 64'(pe_en), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 64'(busy), 64'd0);

    // start -> one CLEAR cycle -> STREAM
    start = 1'b1;
    step();
    start = 1'b0;
    check("clear_pe_clr", 64'(pe_clr), 64'd1);
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_in_ready", 64'(in_ready), 64'd0);
    check("clear_state", 64'(state_dbg), 64'd1);
    step();
    check("stream_pe_clr", 64'(pe_clr), 64'd0);
    check("stream_in_ready", 64'(in_ready), 64'd1);
    check("stream_pe_en", 64'(pe_en), 64'd1);

    // Identity A, B[k][j] = 8k+j, K=8, no bubbles
    for (int k = 0; k < N; k++) begin
      drive_slot(k, 1'b1, k == N - 1);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_pe_en", 64'(pe_en), 64'd1);
    wait_done(1, lat);
    check("ident_done_latency", 64'(lat), 64'(2 * N));
    check("done_pe_en", 64'(pe_en), 64'd0);
    check("done_busy", 64'(busy), 64'd1);
    check_identity_acc("ident_acc");
    step();
    check("after_done_pulse", 64'(done), 64'd0);
    check("after_done_busy", 64'(busy), 64'd0);

    // Skew: K=1, a lanes 1..8, b lanes 9..16
    begin_op();
    in_valid = 1'b1; in_last = 1'b1;
    for (int l = 0; l < N; l++) begin
      a_col[l*DW +: DW] = DW'(l + 1);
      b_row[l*DW +: DW] = DW'(l + 9);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    for (int t = 1; t <= 2 * N; t++) begin
      for (int l = 0; l < N; l++) begin
        check($sformatf("skew_a_t%0d_l%0d", t, l), 64'(a_feed[l*DW +: DW]),
              (t == l + 1) ? 64'(l + 1) : 64'd0);
        check($sformatf("skew_b_t%0d_l%0d", t, l), 64'(b_feed[l*DW +: DW]),
              (t == l + 1) ? 64'(l + 9) : 64'd0);
      end
      check($sformatf("skew_done_t%0d", t), 64'(done), (t == 2 * N) ? 64'd1 : 64'd0);
      if (t < 2 * N) step();
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("k1_acc[%0d][%0d]", i, j), 64'(acc[i][j]), 64'((i + 1) * (j + 9)));
    step();

    // Identity op with bubbles; start pulses in STREAM and FLUSH must be ignored
    begin_op();
    for (int k = 0; k < N; k++) begin
      drive_slot(k, 1'b1, k == N - 1);
      step();
      if (k < N - 1) begin
        drive_slot(k, 1'b0, 1'b0);
        if (k == 3) start = 1'b1;
        step();
        start = 1'b0;
        if (k == 3) begin
          check("start_in_stream_pe_clr", 64'(pe_clr), 64'd0);
          check("start_in_stream_ready", 64'(in_ready), 64'd1);
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_flush_pe_clr", 64'(pe_clr), 64'd0);
    check("start_in_flush_state", 64'(state_dbg), 64'd3);
    wait_done(2, lat);
    check("bubble_done_latency", 64'(lat), 64'(2 * N));
    check_identity_acc("bubble_acc");
    step();

    // rst mid-STREAM, coincident with a start pulse
    begin_op();
    for (int k = 0; k < 3; k++) begin
      drive_slot(k + 2, 1'b1, 1'b0);
      step();
    end
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_a_feed", 64'(a_feed), 64'd0);
    check("midrst_b_feed", 64'(b_feed), 64'd0);
    check("midrst_pe_en", 64'(pe_en), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    seen = 0;
    for (int t = 0; t < 2 * N + 4; t++) begin
      step();
      if (done || busy || pe_clr) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);

`ifdef SYSTOLIC_FEEDER_KCOUNT_EN
    // K=5 with 3 bubbles: v b v b v b v v
    begin_op();
    for (int s = 0; s < 8; s++) begin
      drive_slot(s, (s % 2 == 0) || s >= 6, s == 7);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(1, lat);
    check("kcnt_done_latency", 64'(lat), 64'(2 * N));
    check("kcnt_at_done", 64'(k_count), 64'd5);
    step();
    check("kcnt_idle_hold", 64'(k_count), 64'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("kcnt_cleared", 64'(k_count), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Operand transmitter for the NxN systolic array of PE nodes.
- Accepts one k-slot per handshake: column k of A and row k of B.
- Skews A lanes per row and B lanes per column, then drives the west-edge a_in and north-edge b_in of the array.
- Sequences the array's clear and enable, zero-pads the pipeline tail, and pulses done once every PE accumulator holds the final C = A x B.

Parameters:
N, 8, array dimension (rows = cols = N); N >= 2
DATA_W, 8, operand width; matches the PE DATA_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a matrix op; ignored unless in IDLE
in_valid  input  1  a_col/b_row/in_last carry a valid k-slot
in_ready  output  1  feeder accepts a slot this cycle
in_last  input  1  accepted slot is the final k-slot of the op
a_col  input  N*DATA_W  A[:,k]; lane i (bits i*DATA_W +: DATA_W) goes to array row i
b_row  input  N*DATA_W  B[k,:]; lane j goes to array column j
a_feed  output  N*DATA_W  lane i drives a_in of PE[i][0]
b_feed  output  N*DATA_W  lane j drives b_in of PE[0][j]
pe_clr  output  1  array clear, ORed with rst at the PE rst pins
pe_en  output  1  array accumulate enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: all PE acc values are final and stable

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, all skew registers=0, a_feed=b_feed=0, pe_clr=pe_en=in_ready=busy=done=0. The same applies when rst asserts mid-operation; the partial op is abandoned.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE: on start -> CLEAR.
- CLEAR: one cycle.
  - pe_clr=1.
  - All skew registers zeroed.
  - -> STREAM.
- STREAM:
  - in_ready=1 and pe_en=1.
  - Each cycle pushes one slot into the skew line: the input lanes if in_valid, otherwise zeros (bubble).
  - Bubbles are harmless: PE[i][j] always pairs a and b from the same slot, and 0*0 adds nothing.
  - Accepting a slot with in_last=1 -> FLUSH and loads the flush counter with 2N-1.
- FLUSH:
  - in_ready=0 and pe_en=1.
  - Zero slots are pushed.
  - Counter decrements each cycle; -> DONE after 2N-1 cycles.
- DONE: done=1 and pe_en=0 for one cycle; -> IDLE.
- Skew timing:
  - A slot accepted in cycle c appears on a_feed lane i at cycle c+1+i and on b_feed lane j at cycle c+1+j.
  - Lane 0 has 1 register; lane i has i+1 registers (triangular shift array, N(N+1)/2 registers per matrix).
  - PE[i][j] accumulates the product at the edge ending cycle c+1+i+j.
  - The last product therefore lands at the end of cycle c+2N-1, the final FLUSH cycle.
  - done asserts at c+2N.
- Latency:
  - From start to the first possible acceptance: 2 cycles (CLEAR, then STREAM).
  - From in_last acceptance to done: 2N cycles.
- Slot counts:
  - K = number of accepted slots; K >= 1.
  - in_valid & in_last in the first STREAM cycle is legal (K=1).
- Simultaneous events:
  - start in any non-IDLE state is ignored.
  - start coincident with rst: rst wins.
  - in_valid with in_ready=0: no acceptance; the source must hold.
- Arithmetic: the feeder performs none. Accumulator width and overflow are the PE's concern.
- Output timing: all outputs are registered except in_ready, which is decoded from state.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_KCOUNT_EN.
- Defined:
  - Adds output port k_count (16 bits), counting accepted slots of the current op.
  - Cleared in CLEAR and on rst; saturates at 16'hFFFF.
  - Holds its value through DONE and IDLE until the next start.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N=8, rst held 2 cycles -> all outputs 0, busy=0; start pulse -> pe_clr=1 for exactly 1 cycle, then in_ready=1.
- Identity A (a_col lane k = 1, others 0) with B[k][j]=k*8+j, K=8, no bubbles -> done exactly 16 cycles after the in_last acceptance; array acc[i][j]=i*8+j.
- Skew check, K=1, a_col lanes = 1..8, b_row lanes = 9..16, accepted at cycle c -> a_feed lane i = i+1 at cycle c+1+i and 0 otherwise; b_feed lane j = j+9 at cycle c+1+j.
- The K=8 op from the identity case with in_valid deasserted every other cycle (bubbles) -> identical acc results; done 16 cycles after the in_last acceptance.
- start pulsed during STREAM and FLUSH -> ignored, no second pe_clr; rst asserted mid-STREAM -> IDLE next cycle, feeds zeroed, no done pulse.
- With SYSTOLIC_FEEDER_KCOUNT_EN, K=5 with 3 bubbles -> k_count=5 at done; the next start clears it to 0.
